// File: rtl/contador_updown_param.sv
// Parametrised up/down counter: wrap or saturate, clamped synchronous load, terminal flags, overflow/underflow pulses.
// Optional macro CONTADOR_EDGE_EN adds a 2-FF synchroniser and rising-edge detector on up/down (one step per press).
module contador_updown_param #(
    parameter int unsigned     WIDTH     = 32'd8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              WRAP      = 1'b1,
    parameter longint unsigned INIT      = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             inc_s;
    logic             dec_s;

    // Loads above the terminal count are clipped so the counter never leaves 0..MAX_COUNT.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        if (value > MAX_C) begin
            clamp_load = MAX_C;
        end else begin
            clamp_load = value;
        end
    endfunction

`ifdef CONTADOR_EDGE_EN
    // Bits [1:0] synchronise the raw input; bit [2] is the previous synchronised level.
    logic [2:0] up_sync_q;
    logic [2:0] dn_sync_q;

    // Synchroniser and edge-detector shift registers for both buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_sync_q <= 3'b000;
            dn_sync_q <= 3'b000;
        end else begin
            up_sync_q <= {up_sync_q[1:0], up};
            dn_sync_q <= {dn_sync_q[1:0], down};
        end
    end

    assign inc_s = up_sync_q[1] & ~up_sync_q[2];
    assign dec_s = dn_sync_q[1] & ~dn_sync_q[2];
`else
    assign inc_s = up;
    assign dec_s = down;
`endif

    // Next-state: load beats any step; simultaneous up and down cancel.
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (load) begin
            count_d = clamp_load(load_value);
        end else if (inc_s && !dec_s) begin
            if (count_q < MAX_C) begin
                count_d = count_q + ONE_C;
            end else begin
                overflow_d = 1'b1;
                if (WRAP) begin
                    count_d = ZERO_C;
                end else begin
                    count_d = count_q;
                end
            end
        end else if (dec_s && !inc_s) begin
            if (count_q > ZERO_C) begin
                count_d = count_q - ONE_C;
            end else begin
                underflow_d = 1'b1;
                if (WRAP) begin
                    count_d = MAX_C;
                end else begin
                    count_d = count_q;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= INIT_C;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign at_max    = (count_q == MAX_C);
    assign at_min    = (count_q == ZERO_C);

endmodule

// File: doc/contador_updown_param.md
# contador_updown_param

Parametrised up/down counter; next generation of the team's 4-bit `contador`. Adds configurable width and terminal count, wrap or saturate mode, synchronous load, terminal flags and overflow/underflow pulses. Sits between EDU-CIAA push-button/control logic and display or timing logic. Optionally conditions raw button inputs into one count per press.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits, 2..32.
- `MAX_COUNT`, 2**WIDTH-1: terminal count. Counter range is 0..MAX_COUNT. Must be ≥1 and ≤2**WIDTH-1.
- `WRAP`, 1: 1 = modulo wrap at the ends; 0 = saturate at 0 and at MAX_COUNT.
- `INIT`, 0: reset value of `count`. Must be ≤MAX_COUNT.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `up`, input, 1: count-up request.
- `down`, input, 1: count-down request.
- `load`, input, 1: synchronous load strobe.
- `load_value`, input, WIDTH: value loaded when `load`=1.
- `count`, output, WIDTH: current count (registered).
- `at_max`, output, 1: `count == MAX_COUNT` (combinational from `count`).
- `at_min`, output, 1: `count == 0` (combinational from `count`).
- `overflow`, output, 1: registered one-cycle pulse on an up step at MAX_COUNT.
- `underflow`, output, 1: registered one-cycle pulse on a down step at 0.

## Operation
- Reset (`reset`=0, any time, asynchronous):
  - `count`=INIT; `overflow`=0; `underflow`=0.
  - All conditioning registers cleared to 0.
  - `at_max`/`at_min` follow INIT.
- Let `inc`/`dec` be the effective step requests: raw `up`/`down` levels, or edge pulses when the conditioning feature is compiled in.
- Priority per edge:
  1. `load`=1: `count` ← min(`load_value`, MAX_COUNT). No overflow/underflow pulse. `inc`/`dec` are ignored.
  2. `inc`=1 and `dec`=1: hold `count`. No pulse.
  3. `inc`=1 only:
     - If `count`<MAX_COUNT: `count`+1.
     - If `count`=MAX_COUNT and WRAP=1: `count` ← 0, `overflow`=1.
     - If `count`=MAX_COUNT and WRAP=0: hold, `overflow`=1 (clip indication).
  4. `dec`=1 only:
     - If `count`>0: `count`−1.
     - If `count`=0 and WRAP=1: `count` ← MAX_COUNT, `underflow`=1.
     - If `count`=0 and WRAP=0: hold, `underflow`=1.
  5. Neither request: hold.
- `overflow`/`underflow` are 0 on every edge that does not meet the conditions above. They are never both 1.
- Arithmetic is WIDTH bits. Comparisons are made against MAX_COUNT, never against 2**WIDTH, so non-power-of-2 moduli work.

## Timing
- Level mode:
  - `up`/`down`/`load` are sampled at rising edge k.
  - The new `count` and the pulses are visible after edge k (latency 1).
  - A request held high steps once per cycle.
- Edge mode (macro defined):
  - `up`/`down` pass through a 2-FF synchroniser, then a rising-edge detector.
  - When `up` rises before edge k, `count` changes at edge k+2.
  - Exactly one step occurs per low→high transition, regardless of how long the input is held.
  - `load` is not synchronised and keeps latency 1.
- A reset deassertion has no effect until the next edge. The first step can occur at the first edge after release.

## Configuration
- `CONTADOR_EDGE_EN` defined:
  - Synchroniser and edge detector are instantiated on `up` and `down`.
  - One step per press; latency 3 edges as above.
  - Suited to raw push buttons. Bounce is not filtered; use an upstream debouncer.
- Not defined:
  - `up`/`down` are used directly as synchronous level requests.
  - No extra registers; latency 1.

## Test plan
WIDTH=4, MAX_COUNT=9, INIT=0 unless stated.
- Reset release, then level `up` for 12 cycles, WRAP=1 → `count` 0,1..9,0,1,2. `overflow` is 1 only on the cycle after the 9→0 step; `at_max`=1 while `count`=9.
- WRAP=0, `down` from 0 for 3 cycles → `count` stays 0. `underflow`=1 on each of the 3 cycles; `at_min`=1 throughout.
- `count`=5, `load`=1 with `load_value`=13 and `up`=1 in the same cycle → `count`=9 next cycle. No `overflow`.
- `up`=`down`=1 for 4 cycles at `count`=3 → `count` stays 3. No pulses.
- `reset` asserted mid-count at `count`=7, with INIT=4, between clock edges → `count`=4 immediately, without waiting for a clock edge. `overflow`/`underflow` are 0.
- `CONTADOR_EDGE_EN` defined, `up` held high for 10 cycles, then low, then high again → `count` is 1 at edge k+2 after the first rise, stays 1 while held, and becomes 2 after the second rise.
